// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and default widths for the result accumulator
package addsub_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ACC_W   = 12;
    localparam int DEF_COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - sign-extending accumulator adder with signed overflow detect
// Clamps on overflow when RESULT_ACCUM_SATURATE_EN is defined, wraps otherwise.
module acc_sat_add #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [WIDTH-1:0] i_sum,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovfl
);

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_raw;

    for (genvar g = 0; g < ACC_W; g++) begin : g_ext
        if (g < WIDTH) begin : g_lo
            assign w_ext[g] = i_sum[g];
        end else begin : g_hi
            assign w_ext[g] = i_sum[WIDTH-1];
        end
    end

    assign w_raw  = i_acc + w_ext;
    assign o_ovfl = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_raw[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef RESULT_ACCUM_SATURATE_EN
    // Both operands share a sign on overflow, so the accumulator sign picks the rail.
    assign o_acc = !o_ovfl         ? w_raw :
                   i_acc[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign o_acc = w_raw;
`endif

endmodule

// File: rtl/result_accumulator.sv
// rtl/result_accumulator.sv - batch accumulator for the add/sub result stream
// Optional clamp on overflow via RESULT_ACCUM_SATURATE_EN (see acc_sat_add).
module result_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] batch_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic               in_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [COUNT_W-1:0] out_carries,
    output logic               out_ovfl,
    output logic               busy
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_carries;
    logic               r_ovfl;

    logic [ACC_W-1:0]   w_next_acc;
    logic               w_add_ovfl;
    logic               w_accept;

    acc_sat_add #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc  (r_acc),
        .i_sum  (in_sum),
        .o_acc  (w_next_acc),
        .o_ovfl (w_add_ovfl)
    );

    assign in_ready    = (r_state == RUN);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign w_accept    = in_valid && in_ready;
    assign out_acc     = r_acc;
    assign out_carries = r_carries;
    assign out_ovfl    = r_ovfl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_carries <= '0;
            r_ovfl    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc     <= '0;
                        r_carries <= '0;
                        r_ovfl    <= 1'b0;
                        r_count   <= batch_len;
                        r_state   <= (batch_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_acc   <= w_next_acc;
                        r_ovfl  <= r_ovfl | w_add_ovfl;
                        r_count <= r_count - COUNT_W'(1);
                        // Carry count sticks at all-ones rather than wrapping.
                        if (!(&r_carries)) begin
                            r_carries <= r_carries + COUNT_W'(in_cout);
                        end
                        if (r_count == COUNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// tb/tb_result_accumulator.sv - directed vector bench for result_accumulator
module tb_result_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  batch_len;
    logic        in_valid;
    logic [7:0]  in_sum;
    logic        in_cout;
    logic        out_ready;

    logic        in_ready,  in_ready8;
    logic        out_valid, out_valid8;
    logic [11:0] out_acc;
    logic [7:0]  out_acc8;
    logic [3:0]  out_carries, out_carries8;
    logic        out_ovfl, out_ovfl8;
    logic        busy, busy8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    result_accumulator #(.WIDTH(8), .ACC_W(12), .COUNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .batch_len(batch_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_carries(out_carries), .out_ovfl(out_ovfl), .busy(busy)
    );

    result_accumulator #(.WIDTH(8), .ACC_W(8), .COUNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .batch_len(batch_len),
        .in_valid(in_valid), .in_ready(in_ready8), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid8), .out_ready(out_ready), .out_acc(out_acc8),
        .out_carries(out_carries8), .out_ovfl(out_ovfl8), .busy(busy8)
    );

    typedef struct {
        logic [3:0]      len;
        logic [3:0][7:0] sums;
        logic [3:0]      couts;
        bit              gap;
        logic [11:0]     acc;
        logic [3:0]      car;
        logic            ovfl;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        @(negedge clk);
        start     = 1'b1;
        batch_len = v.len;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(v.len); i++) begin
            if (v.gap) begin
                in_valid = 1'b0;
                in_sum   = 8'hAA;
                in_cout  = 1'b1;
                @(negedge clk);
            end
            chk($sformatf("v%0d in_ready[%0d]", k, i), 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_sum   = v.sums[i % 4];
            in_cout  = v.couts[i % 4];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d out_acc", k), 32'(out_acc), 32'(v.acc));
        chk($sformatf("v%0d out_carries", k), 32'(out_carries), 32'(v.car));
        chk($sformatf("v%0d out_ovfl", k), 32'(out_ovfl), 32'(v.ovfl));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d post out_valid", k), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d post busy", k), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{len: 4'd3,  sums: {8'h00, 8'h10, 8'hFE, 8'h05}, couts: 4'b0110, gap: 1'b0,
                    acc: 12'h013, car: 4'd2,  ovfl: 1'b0};
        vecs[1] = '{len: 4'd3,  sums: {8'h00, 8'h10, 8'hFE, 8'h05}, couts: 4'b0110, gap: 1'b1,
                    acc: 12'h013, car: 4'd2,  ovfl: 1'b0};
        vecs[2] = '{len: 4'd4,  sums: {8'h80, 8'h80, 8'h80, 8'h80}, couts: 4'b1111, gap: 1'b0,
                    acc: 12'hE00, car: 4'd4,  ovfl: 1'b0};
        vecs[3] = '{len: 4'd0,  sums: {8'h00, 8'h00, 8'h00, 8'h00}, couts: 4'b0000, gap: 1'b0,
                    acc: 12'h000, car: 4'd0,  ovfl: 1'b0};
        vecs[4] = '{len: 4'd15, sums: {8'h7F, 8'h7F, 8'h7F, 8'h7F}, couts: 4'b1111, gap: 1'b0,
                    acc: 12'h771, car: 4'd15, ovfl: 1'b0};
        vecs[5] = '{len: 4'd5,  sums: {8'h81, 8'h7F, 8'h01, 8'hFF}, couts: 4'b0101, gap: 1'b1,
                    acc: 12'hFFF, car: 4'd3,  ovfl: 1'b0};

        rst_n = 1'b0; start = 1'b0; batch_len = 4'd0; in_valid = 1'b0;
        in_sum = 8'h00; in_cout = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_acc", 32'(out_acc), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a 4-input batch
        @(negedge clk);
        start = 1'b1; batch_len = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_sum = 8'h21; in_cout = 1'b1;
            @(negedge clk);
        end
        chk("midrun busy before reset", 32'(busy), 32'd1);
        chk("midrun acc before reset", 32'(out_acc), 32'h042);
        rst_n = 1'b0;
        #1;
        chk("midrun reset out_acc", 32'(out_acc), 32'd0);
        chk("midrun reset out_carries", 32'(out_carries), 32'd0);
        chk("midrun reset out_ovfl", 32'(out_ovfl), 32'd0);
        chk("midrun reset busy", 32'(busy), 32'd0);
        chk("midrun reset in_ready", 32'(in_ready), 32'd0);
        chk("midrun reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after reset in_ready", 32'(in_ready), 32'd0);
            chk("after reset out_valid", 32'(out_valid), 32'd0);
            chk("after reset out_acc", 32'(out_acc), 32'd0);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], k);
        end

        // Backpressure in DONE with start and in_valid noise
        @(negedge clk);
        start = 1'b1; batch_len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_sum = 8'h10; in_cout = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; batch_len = 4'd3; in_valid = 1'b1; in_sum = 8'h7F; in_cout = 1'b1;
            @(negedge clk);
            chk($sformatf("bp out_valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp out_acc[%0d]", i), 32'(out_acc), 32'h010);
            chk($sformatf("bp out_carries[%0d]", i), 32'(out_carries), 32'd1);
            chk($sformatf("bp in_ready[%0d]", i), 32'(in_ready), 32'd0);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release busy", 32'(busy), 32'd0);
        chk("bp release out_valid", 32'(out_valid), 32'd0);

        // Overflow: three 8'h7F into an 8-bit accumulator
        @(negedge clk);
        start = 1'b1; batch_len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sum = 8'h7F; in_cout = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ovf8 out_valid", 32'(out_valid8), 32'd1);
        chk("ovf8 out_ovfl", 32'(out_ovfl8), 32'd1);
`ifdef RESULT_ACCUM_SATURATE_EN
        chk("ovf8 out_acc", 32'(out_acc8), 32'h7F);
`else
        chk("ovf8 out_acc", 32'(out_acc8), 32'h7D);
`endif
        chk("ovf12 out_acc", 32'(out_acc), 32'h17D);
        chk("ovf12 out_ovfl", 32'(out_ovfl), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ovf8 release busy", 32'(busy8), 32'd0);
        chk("ovf8 ovfl still visible", 32'(out_ovfl8), 32'd1);

        // New batch clears the sticky flag
        run_vec(vecs[3], 6);
        chk("ovf8 cleared by start", 32'(out_ovfl8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
